// File: rtl/risk_limit_table.sv
// risk_limit_table: per-client pre-trade limit/accumulator table, one
// read-modify-write transaction in flight (ORDER/SET_MAX/CLEAR/QUERY).
// Ports: clk, rst (sync, active-high); req_* valid/ready request channel
// (op, client, amount); rsp_* valid/ready response channel (status, client,
// post-op max/accum/defined). Optional build macro RISK_STATS_EN adds
// saturating stat_accepted / stat_rejected ORDER counters.
module risk_limit_table #(
  parameter int CLIENTS = 32,
  parameter int AMT_W   = 16,
  parameter int ID_W    = (CLIENTS > 1) ? $clog2(CLIENTS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [ID_W-1:0]  req_client,
  input  logic [AMT_W-1:0] req_amount,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_status,
  output logic [ID_W-1:0]  rsp_client,
  output logic [AMT_W-1:0] rsp_max,
  output logic [AMT_W-1:0] rsp_accum,
  output logic             rsp_defined
`ifdef RISK_STATS_EN
  ,
  output logic [31:0]      stat_accepted,
  output logic [31:0]      stat_rejected
`endif
);

  localparam logic [1:0] OP_ORDER = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_QUERY = 2'b11;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_LIMIT   = 2'b01;
  localparam logic [1:0] ST_NOLIMIT = 2'b10;
  localparam logic [1:0] ST_BADID   = 2'b11;

  localparam logic [ID_W:0]   NCLI = (ID_W+1)'(CLIENTS);
  localparam logic [ID_W-1:0] LAST = ID_W'(CLIENTS - 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_READ,
    S_EXEC,
    S_RESP
  } state_t;

  state_t state;

  logic [AMT_W-1:0] mem_max   [CLIENTS];
  logic [AMT_W-1:0] mem_accum [CLIENTS];
  logic             mem_def   [CLIENTS];

  logic [ID_W-1:0]  idx;
  logic [1:0]       op_q;
  logic [ID_W-1:0]  client_q;
  logic [AMT_W-1:0] amount_q;
  logic             bad_q;
  logic [AMT_W-1:0] cur_max;
  logic [AMT_W-1:0] cur_accum;
  logic             cur_def;

  logic [AMT_W:0]   sum;
  logic [AMT_W-1:0] nxt_max;
  logic [AMT_W-1:0] nxt_accum;
  logic             nxt_def;
  logic [1:0]       nxt_status;
  logic             wr;
  logic             client_bad;

  assign client_bad = ({1'b0, client_q} >= NCLI);

  // Execute stage: derive the post-operation entry and status.
  always_comb begin
    sum        = {1'b0, cur_accum} + {1'b0, amount_q};
    nxt_max    = cur_max;
    nxt_accum  = cur_accum;
    nxt_def    = cur_def;
    nxt_status = ST_OK;
    wr         = 1'b0;
    if (bad_q) begin
      nxt_status = ST_BADID;
      nxt_max    = '0;
      nxt_accum  = '0;
      nxt_def    = 1'b0;
    end else begin
      unique case (op_q)
        OP_ORDER: begin
          if (!cur_def) begin
            nxt_status = ST_NOLIMIT;
          end else if (sum > {1'b0, cur_max}) begin
            // includes any carry into bit AMT_W
            nxt_status = ST_LIMIT;
          end else begin
            nxt_accum = sum[AMT_W-1:0];
            wr        = 1'b1;
          end
        end
        OP_SET: begin
          nxt_max = amount_q;
          nxt_def = 1'b1;
          wr      = 1'b1;
        end
        OP_CLEAR: begin
          nxt_accum = '0;
          wr        = 1'b1;
        end
        OP_QUERY: begin
          wr = 1'b0;
        end
        default: begin
          wr = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_INIT;
      idx         <= '0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_status  <= '0;
      rsp_client  <= '0;
      rsp_max     <= '0;
      rsp_accum   <= '0;
      rsp_defined <= 1'b0;
      op_q        <= '0;
      client_q    <= '0;
      amount_q    <= '0;
      bad_q       <= 1'b0;
      cur_max     <= '0;
      cur_accum   <= '0;
      cur_def     <= 1'b0;
    end else begin
      unique case (state)
        S_INIT: begin
          mem_max[idx]   <= '0;
          mem_accum[idx] <= '0;
          mem_def[idx]   <= 1'b0;
          if (idx == LAST) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            client_q  <= req_client;
            amount_q  <= req_amount;
            req_ready <= 1'b0;
            state     <= S_READ;
          end
        end
        S_READ: begin
          bad_q <= client_bad;
          if (client_bad) begin
            cur_max   <= '0;
            cur_accum <= '0;
            cur_def   <= 1'b0;
          end else begin
            cur_max   <= mem_max[client_q];
            cur_accum <= mem_accum[client_q];
            cur_def   <= mem_def[client_q];
          end
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (wr) begin
            mem_max[client_q]   <= nxt_max;
            mem_accum[client_q] <= nxt_accum;
            mem_def[client_q]   <= nxt_def;
          end
          rsp_status  <= nxt_status;
          rsp_client  <= client_q;
          rsp_max     <= nxt_max;
          rsp_accum   <= nxt_accum;
          rsp_defined <= nxt_def;
          rsp_valid   <= 1'b1;
          state       <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_INIT;
          idx   <= '0;
        end
      endcase
    end
  end

`ifdef RISK_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_accepted <= '0;
      stat_rejected <= '0;
    end else if (state == S_EXEC && op_q == OP_ORDER) begin
      if (nxt_status == ST_OK) begin
        if (stat_accepted != 32'hFFFF_FFFF)
          stat_accepted <= stat_accepted + 32'd1;
      end else begin
        if (stat_rejected != 32'hFFFF_FFFF)
          stat_rejected <= stat_rejected + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_risk_limit_table.sv
// tb_risk_limit_table: vector table + scoreboard queue bench for
// risk_limit_table, plus hand-written backpressure and reset sequences.
module tb_risk_limit_table;

  localparam int CLIENTS = 32;
  localparam int AMT_W   = 16;
  localparam int ID_W    = 5;

  logic             clk;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [ID_W-1:0]  req_client;
  logic [AMT_W-1:0] req_amount;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_status;
  logic [ID_W-1:0]  rsp_client;
  logic [AMT_W-1:0] rsp_max;
  logic [AMT_W-1:0] rsp_accum;
  logic             rsp_defined;
`ifdef RISK_STATS_EN
  logic [31:0]      stat_accepted;
  logic [31:0]      stat_rejected;
`endif

  risk_limit_table #(
    .CLIENTS(CLIENTS),
    .AMT_W(AMT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op(req_op),
    .req_client(req_client),
    .req_amount(req_amount),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_status(rsp_status),
    .rsp_client(rsp_client),
    .rsp_max(rsp_max),
    .rsp_accum(rsp_accum),
    .rsp_defined(rsp_defined)
`ifdef RISK_STATS_EN
    ,
    .stat_accepted(stat_accepted),
    .stat_rejected(stat_rejected)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       op;
    logic [ID_W-1:0]  client;
    logic [AMT_W-1:0] amount;
    logic [1:0]       status;
    logic [AMT_W-1:0] max;
    logic [AMT_W-1:0] accum;
    logic             def;
  } vec_t;

  vec_t vecs[16];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_acc = 0;
  int   exp_rej = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] op, input int cl,
                              input int amt, input logic [1:0] st,
                              input int mx, input int ac, input logic df);
    vec_t v;
    v.op     = op;
    v.client = ID_W'(cl);
    v.amount = AMT_W'(amt);
    v.status = st;
    v.max    = AMT_W'(mx);
    v.accum  = AMT_W'(ac);
    v.def    = df;
    return v;
  endfunction

  task automatic wait_ready(output int n);
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'd1);
  endtask

  // Issue one request from v; leaves the response pending (rsp_ready=0).
  task automatic issue(input vec_t v);
    int n;
    int lat;
    wait_ready(n);
    req_valid  = 1'b1;
    req_op     = v.op;
    req_client = v.client;
    req_amount = v.amount;
    sb.push_back(v);
    @(negedge clk);
    req_valid  = 1'b0;
    req_amount = '1;
    lat = 1;
    chk("ready_low_busy", 32'(req_ready), 32'd0);
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'd3);
  endtask

  task automatic check_rsp(input string tag);
    vec_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_status"}, 32'(rsp_status), 32'(e.status));
      chk({tag, "_client"}, 32'(rsp_client), 32'(e.client));
      chk({tag, "_max"}, 32'(rsp_max), 32'(e.max));
      chk({tag, "_accum"}, 32'(rsp_accum), 32'(e.accum));
      chk({tag, "_def"}, 32'(rsp_defined), 32'(e.def));
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_drop", 32'(rsp_valid), 32'd0);
  endtask

  task automatic count_init(input string tag);
    int n;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n), 32'(CLIENTS));
  endtask

  initial begin
    logic [1:0]       s_st;
    logic [AMT_W-1:0] s_mx;
    logic [AMT_W-1:0] s_ac;
    logic             s_df;
    int               stable;

    vecs[0]  = mk(2'b11, 5, 0, 2'b00, 0, 0, 0);
    vecs[1]  = mk(2'b00, 3, 'h10, 2'b10, 0, 0, 0);
    vecs[2]  = mk(2'b11, 3, 0, 2'b00, 0, 0, 0);
    vecs[3]  = mk(2'b01, 3, 'h100, 2'b00, 'h100, 0, 1);
    vecs[4]  = mk(2'b00, 3, 'hF0, 2'b00, 'h100, 'hF0, 1);
    vecs[5]  = mk(2'b00, 3, 'h10, 2'b00, 'h100, 'h100, 1);
    vecs[6]  = mk(2'b00, 3, 1, 2'b01, 'h100, 'h100, 1);
    vecs[7]  = mk(2'b01, 7, 'hFFFF, 2'b00, 'hFFFF, 0, 1);
    vecs[8]  = mk(2'b00, 7, 'hFFF0, 2'b00, 'hFFFF, 'hFFF0, 1);
    vecs[9]  = mk(2'b00, 7, 'h20, 2'b01, 'hFFFF, 'hFFF0, 1);
    vecs[10] = mk(2'b10, 7, 'h1234, 2'b00, 'hFFFF, 0, 1);
    vecs[11] = mk(2'b00, 7, 0, 2'b00, 'hFFFF, 0, 1);
    vecs[12] = mk(2'b01, 3, 'h80, 2'b00, 'h80, 'h100, 1);
    vecs[13] = mk(2'b00, 3, 1, 2'b01, 'h80, 'h100, 1);
    vecs[14] = mk(2'b11, 31, 0, 2'b00, 0, 0, 0);
    vecs[15] = mk(2'b01, 31, 5, 2'b00, 5, 0, 1);

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_op     = '0;
    req_client = '0;
    req_amount = '0;
    rsp_ready  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_fields",
        {8'd0, rsp_status, rsp_client, rsp_max, rsp_defined},
        32'd0);
    chk("rst_rsp_accum", 32'(rsp_accum), 32'd0);
    rst = 1'b0;
    count_init("init_cycles");

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].op == 2'b00) begin
        if (vecs[i].status == 2'b00) exp_acc++;
        else exp_rej++;
      end
      issue(vecs[i]);
      check_rsp($sformatf("v%0d", i));
      consume();
    end

`ifdef RISK_STATS_EN
    chk("stat_accepted", stat_accepted, 32'(exp_acc));
    chk("stat_rejected", stat_rejected, 32'(exp_rej));
`endif

    // Backpressure: response fields hold while rsp_ready stays low.
    issue(mk(2'b00, 3, 0, 2'b01, 'h80, 'h100, 1));
    s_st = rsp_status;
    s_mx = rsp_max;
    s_ac = rsp_accum;
    s_df = rsp_defined;
    check_rsp("bp");
    stable = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!rsp_valid || req_ready || rsp_status !== s_st ||
          rsp_max !== s_mx || rsp_accum !== s_ac || rsp_defined !== s_df)
        stable = 0;
    end
    chk("bp_stable", 32'(stable), 32'd1);

    // Reset while the response is pending drops it and re-runs the sweep.
    rst = 1'b1;
    @(negedge clk);
    chk("rst_resp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_resp_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    count_init("reinit_cycles");
    issue(mk(2'b11, 3, 0, 2'b00, 0, 0, 0));
    check_rsp("post_rst");
    consume();
    issue(mk(2'b11, 7, 0, 2'b00, 0, 0, 0));
    check_rsp("post_rst7");
    consume();
`ifdef RISK_STATS_EN
    chk("stat_acc_rst", stat_accepted, 32'd0);
    chk("stat_rej_rst", stat_rejected, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/risk_limit_table.md
# risk_limit_table

Parametrised per-client pre-trade risk table for the upstream order path, holding a maximum-to-trade limit and an accumulated-sent amount for every client ID. Each incoming request is handled as a single read-modify-write transaction: order check-and-accumulate, limit programming, accumulator clear, or query. The block sits between the order generator and the upstream send logic and replaces the fixed 16/16-bit packed client line with configurable depth and widths. It adds explicit reject statuses, a defined-limit flag and a post-reset table initialisation sweep.

## Interface
- CLIENTS, 32: number of client entries; legal IDs are 0..CLIENTS-1.
- AMT_W, 16: width of the limit, the accumulator and the order amount.
- ID_W, $clog2(CLIENTS) (minimum 1): client ID width.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when high together with req_valid at a rising edge.
- req_op  in  2  operation: 00 ORDER, 01 SET_MAX, 10 CLEAR, 11 QUERY.
- req_client  in  ID_W  client ID.
- req_amount  in  AMT_W  order amount (ORDER) or new limit (SET_MAX); ignored for CLEAR and QUERY.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when high together with rsp_valid at a rising edge.
- rsp_status  out  2  status: 00 OK/ACCEPT, 01 REJ_LIMIT, 10 REJ_NOLIMIT, 11 BAD_ID.
- rsp_client  out  ID_W  echo of req_client.
- rsp_max  out  AMT_W  entry limit after the operation.
- rsp_accum  out  AMT_W  entry accumulator after the operation.
- rsp_defined  out  1  entry defined flag after the operation.

## Operation
- Entry contents: max[AMT_W], accum[AMT_W], defined[1], stored in a CLIENTS-deep register array.
- States:
  - INIT: sweep idx 0..CLIENTS-1 and write all-zero entries, one entry per cycle, then go to IDLE.
  - IDLE: req_ready=1. On handshake, capture the request and go to READ.
  - READ: register the addressed entry.
  - EXEC: compute, write the entry, register the response, go to RESP.
  - RESP: rsp_valid=1. On rsp_ready, go to IDLE.
- ORDER:
  - defined=0: REJ_NOLIMIT, no write.
  - Otherwise, compute sum = accum + amount at AMT_W+1 bits.
  - sum <= max: ACCEPT, and accum is updated to sum[AMT_W-1:0].
  - sum > max: REJ_LIMIT, entry unchanged.
  - A carry into bit AMT_W always rejects.
  - amount=0 with a defined limit is accepted.
- SET_MAX: max=amount, defined=1, status OK. accum is untouched, even when the new max is below accum; later non-zero orders then reject.
- CLEAR: accum=0, status OK. max and defined are untouched.
- QUERY: no write, status OK.
- Client ID >= CLIENTS (only possible when CLIENTS is not a power of two): BAD_ID, no write, and rsp_max/rsp_accum/rsp_defined read as 0.
- rsp_* fields always report the post-operation entry.
- Only one transaction is in flight at a time, so there are no read-after-write hazards.

## Timing
- Reset, sampled at a rising edge:
  - State goes to INIT and the sweep index goes to 0.
  - req_ready=0, rsp_valid=0, and rsp_status, rsp_client, rsp_max, rsp_accum, rsp_defined=0.
- INIT lasts exactly CLIENTS cycles. req_ready first goes high CLIENTS cycles after rst deasserts.
- Request accepted at edge E0 → READ during cycle E0..E1 → EXEC E1..E2.
- The entry write and the response registers update at E2, so rsp_valid is high from E2: 2-cycle latency.
- req_ready is low from E0 until the cycle after the response handshake. Peak rate is one transaction per 4 cycles when rsp_ready is held high.
- rsp_* fields are stable while rsp_valid=1 and rsp_ready=0.
- Reset mid-transaction: the pending response is dropped, any uncommitted write is discarded, and the table is re-initialised by INIT.
- A write already committed at E2 is overwritten by the INIT sweep.
- req_* inputs are ignored outside IDLE.

## Configuration
- RISK_STATS_EN defined:
  - Adds outputs stat_accepted [31:0] and stat_rejected [31:0].
  - The counters count ORDER responses at the EXEC commit: ACCEPT, and REJ_LIMIT/REJ_NOLIMIT/BAD_ID respectively. BAD_ID counts only for ORDER ops.
  - The counters saturate at 0xFFFFFFFF and are reset to 0 by rst.
- RISK_STATS_EN undefined: the ports and counters do not exist, and behaviour is otherwise identical.

## Test plan
- Reset, then count cycles until req_ready: exactly CLIENTS cycles (32 with defaults). QUERY client 5 → OK, max=0, accum=0, defined=0.
- ORDER client 3 amount 0x0010 with the limit undefined → REJ_NOLIMIT; a following QUERY shows accum=0.
- SET_MAX client 3 = 0x0100, then ORDER 0x00F0 → ACCEPT, accum=0x00F0. ORDER 0x0010 → ACCEPT, accum=0x0100 (exact limit). ORDER 0x0001 → REJ_LIMIT, accum stays 0x0100.
- Overflow: SET_MAX client 7 = 0xFFFF, ORDER 0xFFF0, then ORDER 0x0020 → second order REJ_LIMIT (carry), accum=0xFFF0. CLEAR → accum=0, max=0xFFFF.
- Backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid → fields stable and req_ready=0. Assert rst in RESP → rsp_valid drops next cycle and INIT restarts.
- With RISK_STATS_EN: 3 accepts and 2 rejects → stat_accepted=3, stat_rejected=2. Preload stat_accepted=0xFFFFFFFF and send one more accept → it stays 0xFFFFFFFF.
